input_arbiter: RTL and testbench

- Replaces the static DIP-driven source select in front of the SNES encoder with a sequenced arbiter.
- Shares the encoder between three requesters: keyboard, IR and button board.
- Ownership is granted on activity and released after an idle hold time.
- The 8-bit button word reaching the encoder is updated only on SNES latch edges, so a console frame never sees a mid-frame source change.

---
 rtl/input_arbiter_pkg.sv | 54 +++++
 rtl/input_arbiter_if.sv | 41 ++++
 rtl/input_arbiter_latch_sync.sv | 36 +++
 rtl/input_arbiter.sv | 158 +++++++++++++++
 tb/tb_input_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/input_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_pkg                                                      |
// | Description : Shared types, constants and the request-priority helpers     |
// |               used by the SNES input arbiter.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package arb_pkg;

  // Encoding matches the owner output pins and the dip force codes.
  typedef enum logic [1:0] {
    OWN_KEY  = 2'd0,
    OWN_IR   = 2'd1,
    OWN_BTN  = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    FORCED = 2'd2
  } state_t;

  // dip value selecting automatic arbitration; any other value forces a source.
  localparam logic [1:0] DIP_AUTO = 2'b11;

  // active[0]=key, active[1]=IR, active[2]=button. Button beats key beats IR.
  function automatic owner_t prio_pick(input logic [2:0] active);
    owner_t pick;
    pick = OWN_NONE;
    if (active[2]) begin
      pick = OWN_BTN;
    end else if (active[0]) begin
      pick = OWN_KEY;
    end else if (active[1]) begin
      pick = OWN_IR;
    end
    return pick;
  endfunction

  // Numeric rank for priority comparison; larger wins, "none" ranks lowest.
  function automatic logic [1:0] prio_rank(input owner_t who);
    logic [1:0] rank;
    case (who)
      OWN_BTN: rank = 2'd3;
      OWN_KEY: rank = 2'd2;
      OWN_IR:  rank = 2'd1;
      default: rank = 2'd0;
    endcase
    return rank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_arbiter_if                                             |
// | Description : Source words, mode select and console latch going into the  |
// |               arbiter, plus the encoder word and status coming out.        |
// |               slave = arbiter side, master = driving/observing side.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface input_arbiter_if;
  logic [7:0] key_data;
  logic [7:0] ir_data;
  logic [7:0] btn_data;
  logic [1:0] dip;
  logic       snes_latch;
  logic [7:0] mux_en;
  logic [1:0] owner;
  logic       frame_tick;

  modport slave (
    input  key_data,
    input  ir_data,
    input  btn_data,
    input  dip,
    input  snes_latch,
    output mux_en,
    output owner,
    output frame_tick
  );

  modport master (
    output key_data,
    output ir_data,
    output btn_data,
    output dip,
    output snes_latch,
    input  mux_en,
    input  owner,
    input  frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/input_arbiter_latch_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : latch_sync                                                   |
// | Description : Brings the console latch into the clk domain through a       |
// |               SYNC_STAGES flop chain and emits a one-cycle pulse on each   |
// |               rising edge of the synchronized signal.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module latch_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic latch_i,
  output logic latch_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Synchronizer chain plus the previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], latch_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held-high latch yields a single pulse; re-arming needs a low sample.
  assign latch_pulse_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/input_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_arbiter                                                |
// | Description : Shares the SNES encoder between keyboard, IR and button      |
// |               board. Ownership is granted on activity and dropped after    |
// |               HOLD_CYCLES idle cycles; dip forces a fixed source. The      |
// |               encoder word only changes on console latch edges.           |
// | Options     : ARB_PREEMPT_EN - a strictly higher-priority request takes    |
// |               ownership from the current owner.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module input_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 500000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset_n,
  input_arbiter_if.slave bus
);

  // Last idle count before release.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       dip_q;
  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mux_q;
  logic             tick_q;

  logic [2:0]       active_w;
  owner_t           pick_w;
  logic             owner_active_w;
  logic [7:0]       sel_word_w;
  logic             latch_pulse_w;

  latch_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_latch_sync (
    .clk           (clk),
    .reset_n       (reset_n),
    .latch_i       (bus.snes_latch),
    .latch_pulse_o (latch_pulse_w)
  );

  assign active_w = {|bus.btn_data, |bus.ir_data, |bus.key_data};
  assign pick_w   = prio_pick(active_w);

  // Whether the current owner is showing activity this cycle.
  always_comb begin
    owner_active_w = 1'b0;
    case (owner_q)
      OWN_KEY: owner_active_w = active_w[0];
      OWN_IR:  owner_active_w = active_w[1];
      OWN_BTN: owner_active_w = active_w[2];
      default: owner_active_w = 1'b0;
    endcase
  end

  // Word the encoder would receive if a latch arrived this cycle.
  always_comb begin
    sel_word_w = 8'h00;
    if (state_q != IDLE) begin
      case (owner_q)
        OWN_KEY: sel_word_w = bus.key_data;
        OWN_IR:  sel_word_w = bus.ir_data;
        OWN_BTN: sel_word_w = bus.btn_data;
        default: sel_word_w = 8'h00;
      endcase
    end
  end

  // Arbitration next-state: forced mode, grant from idle, hold/release in OWN.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (dip_q != DIP_AUTO) begin
      // Forced source follows dip_q directly; idle timing is irrelevant here.
      state_d = FORCED;
      owner_d = owner_t'(dip_q);
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          owner_d = OWN_NONE;
          cnt_d   = '0;
          if (|active_w) begin
            state_d = OWN;
            owner_d = pick_w;
          end
        end
        OWN: begin
          if (owner_active_w) begin
            cnt_d = '0;
          end else if (cnt_q >= HOLD_LAST) begin
            // Release takes precedence over any competing request this cycle.
            state_d = IDLE;
            owner_d = OWN_NONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`ifdef ARB_PREEMPT_EN
          if ((state_d == OWN) && (|active_w) &&
              (prio_rank(pick_w) > prio_rank(owner_q))) begin
            owner_d = pick_w;
            cnt_d   = '0;
          end
`endif
        end
        default: begin
          // Leaving forced mode (or an illegal encoding) restarts arbitration.
          state_d = IDLE;
          owner_d = OWN_NONE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Mode register and arbitration state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dip_q   <= DIP_AUTO;
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
    end else begin
      dip_q   <= bus.dip;
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame-aligned encoder word: reloaded only on a latch pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mux_q  <= 8'h00;
      tick_q <= 1'b0;
    end else begin
      tick_q <= latch_pulse_w;
      if (latch_pulse_w) begin
        mux_q <= sel_word_w;
      end
    end
  end

  assign bus.mux_en     = mux_q;
  assign bus.owner      = owner_q;
  assign bus.frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_input_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_input_arbiter                                             |
// | Description : Self-checking bench for input_arbiter with HOLD_CYCLES=8.    |
// |               Expected encoder words are queued when a latch is driven and |
// |               compared on each frame_tick.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_input_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  input_arbiter_if ifc ();

  input_arbiter #(
    .HOLD_CYCLES (8),
    .CNT_W       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_mux;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One latch: rise, hold three cycles, fall, three quiet cycles.
  task automatic pulse_latch(input logic [7:0] exp);
    sb_q.push_back(exp);
    ifc.snes_latch = 1'b1;
    tick(3);
    ifc.snes_latch = 1'b0;
    tick(3);
    check("latch_load", sb_q.size(), 0);
  endtask

  // Every frame_tick must match exactly one queued latch.
  always @(negedge clk) begin
    if (reset_n && ifc.frame_tick === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("tick_spurious", ifc.frame_tick, 0);
      end else begin
        exp_mux = sb_q.pop_front();
        check("mux_en", ifc.mux_en, exp_mux);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ifc.key_data   = 8'h00;
    ifc.ir_data    = 8'h00;
    ifc.btn_data   = 8'h00;
    ifc.dip        = 2'b11;
    ifc.snes_latch = 1'b0;
    reset_n        = 1'b0;
    tick(2);
    check("rst_owner", ifc.owner, 3);
    check("rst_mux", ifc.mux_en, 8'h00);
    check("rst_tick", ifc.frame_tick, 0);
    reset_n = 1'b1;
    tick(1);

    // Auto mode, nothing active: latches load zero.
    pulse_latch(8'h00);
    pulse_latch(8'h00);
    check("idle_owner", ifc.owner, 3);

    // Single-cycle key activity, latch right after, hold timing.
    ifc.key_data = 8'h05;
    tick(1);
    ifc.key_data = 8'h00;
    check("grant_key", ifc.owner, 0);
    ifc.snes_latch = 1'b1;
    sb_q.push_back(8'h00);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 3) ifc.snes_latch = 1'b0;
      if (i == 7) check("hold_keep", ifc.owner, 0);
      if (i == 8) check("hold_release", ifc.owner, 3);
    end
    tick(3);
    check("latch_load", sb_q.size(), 0);

    // Simultaneous key and button: button wins.
    ifc.key_data = 8'h01;
    ifc.btn_data = 8'h80;
    tick(1);
    check("grant_btn", ifc.owner, 2);
    pulse_latch(8'h80);
    ifc.key_data = 8'h00;
    ifc.btn_data = 8'h00;
    tick(10);
    check("release_btn", ifc.owner, 3);

    // Key owns; IR ignored; button preempts only when enabled.
    ifc.key_data = 8'h05;
    tick(1);
    check("grant_key2", ifc.owner, 0);
    ifc.ir_data = 8'h10;
    tick(2);
    check("ir_ignored", ifc.owner, 0);
    pulse_latch(8'h05);
    ifc.btn_data = 8'h02;
    tick(1);
`ifdef ARB_PREEMPT_EN
    check("preempt", ifc.owner, 2);
    pulse_latch(8'h02);
`else
    check("no_preempt", ifc.owner, 0);
    pulse_latch(8'h05);
`endif
    ifc.key_data = 8'h00;
    ifc.ir_data  = 8'h00;
    ifc.btn_data = 8'h00;
    tick(12);
    check("release_all", ifc.owner, 3);

    // dip change while key owns: owner follows fast, mux_en waits for a latch.
    ifc.key_data = 8'h05;
    tick(1);
    pulse_latch(8'h05);
    ifc.ir_data = 8'h33;
    ifc.dip     = 2'b01;
    tick(2);
    check("forced_owner", ifc.owner, 1);
    check("mux_hold", ifc.mux_en, 8'h05);
    pulse_latch(8'h33);
    check("forced_keep", ifc.owner, 1);
    ifc.dip      = 2'b11;
    ifc.key_data = 8'h00;
    ifc.ir_data  = 8'h00;
    tick(3);
    check("back_auto", ifc.owner, 3);

    // Reset mid-hold, then a fresh full hold interval.
    ifc.key_data = 8'h05;
    tick(1);
    ifc.key_data = 8'h00;
    tick(5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("midrst_mux", ifc.mux_en, 8'h00);
    check("midrst_owner", ifc.owner, 3);
    check("midrst_tick", ifc.frame_tick, 0);
    ifc.key_data = 8'h07;
    tick(1);
    ifc.key_data = 8'h00;
    check("regrant_key", ifc.owner, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) check("restart_keep", ifc.owner, 0);
      if (i == 8) check("restart_release", ifc.owner, 3);
    end
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
